fp_mul_seq: RTL and testbench
=============================

# fp_mul_seq

Sequential IEEE-754 single-precision multiplier, the companion arithmetic unit to the divider's special-case path. It handles the inverse operation: operand classification, the special-value table for multiplication, and an iterative 24-bit shift-add mantissa product with normalisation and rounding. It accepts one operand pair at a time over a valid/ready handshake and returns the result over a valid/ready handshake to the FPU result mux.

## Interface
- `MANT_W`, default 24: significand width including the hidden bit. Also sets the MULT iteration count.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block idle and able to accept. Registered.
- `a`, `b` in 32: IEEE-754 operands.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out` out 32: product.
- `special` out 1: result came from the special-case table.

## Operation
- Operands are classified as ZERO, NORMAL, INF_POS, INF_NEG or NAN. A zero exponent with any mantissa classifies as ZERO (subnormals flush to zero).
- Special table, with `s = a[31]^b[31]`:
  - Any NAN, or ZERO×INF in either order, gives `32'hFF800001`.
  - INF×INF or INF×NORMAL gives `{s, 31'h7F800000}`.
  - ZERO×ZERO or ZERO×NORMAL gives `32'h00000000`.
  - `special` is 1 for all of these.
- NORMAL×NORMAL:
  - 48-bit product of `{1,ma}×{1,mb}`, one multiplier bit per cycle, LSB first.
  - Exponent is `ea+eb-127` in 10-bit signed form.
  - If product bit 47 is set, shift right by 1 and add 1 to the exponent.
- Rounding is per Configuration. A mantissa carry-out from rounding increments the exponent.
- A final exponent ≥255 gives `{s, 31'h7F800000}`. A final exponent ≤0 gives `32'h00000000`. In both cases `special` is 0.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, latch the operands. Special case goes to DONE with the result loaded; otherwise go to MULT with count=0.
  - MULT: one accumulate per cycle. Go to NORM when count reaches `MANT_W-1`.
  - NORM: normalise, round, pack, then go to DONE.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE.
- Only one operation is in flight at a time. `in_ready` is 0 in every state except IDLE.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out`=0, `special`=0, state IDLE. `in_ready` rises on the first clock edge after `rst_n` deasserts.
- Latency is counted from the acceptance cycle to the first cycle `out_valid` is high:
  - Special case: 1 cycle.
  - Normal case: `MANT_W`+2 = 26 cycles.
- `out` and `special` are stable while `out_valid`=1 and `out_ready`=0.
- `out_valid` drops and `in_ready` rises on the same edge that samples `out_ready`=1. A new pair can therefore be accepted in the next cycle, not the same one.
- Asserting `rst_n` low in any state discards the operation immediately and applies the reset values.
- `in_valid` asserted while `in_ready`=0 is ignored. The source must hold its operands until accepted.

## Configuration
- `FP_MUL_RNE_EN`:
  - Defined: round-to-nearest-even using guard and sticky bits from the low 24 product bits. An exact tie rounds to an even LSB.
  - Undefined: truncate, with no guard/sticky logic. Latency is identical in both builds.

## Structure
- Shared package `fp_pkg` holds:
  - The 3-bit class codes.
  - `NAN_NUM` = `32'hFF800001`, `INF_ABS` = `31'h7F800000`, `BIAS` = 127.
  - The FSM state typedef.
- The divider reuses `fp_pkg`.
- One sub-module, `fp_classify`, is instantiated once per operand: 32-bit input, 3-bit class output, and an `is_special` output.

## Test plan
- `a=32'h40400000`, `b=32'h40000000` (3.0×2.0) → `out=32'h40C00000`, `special`=0, `out_valid` 26 cycles after acceptance.
- `a=32'h00000000`, `b=32'h7F800000` → `out=32'hFF800001`, `special`=1, latency 1. Repeat with `b=32'h7FC00000` → same result.
- `a=32'hC0000000`, `b=32'h7F800000` → `32'hFF800000`. Overflow case `a=32'h7F000000`, `b=32'h40000000` → `32'h7F800000`, `special`=0.
- Tie rounding, `a=32'h3FC00000`, `b=32'h3F800001` → `32'h3FC00002` with `FP_MUL_RNE_EN`, `32'h3FC00001` without.
- Hold `out_ready`=0 for 10 cycles in DONE → `out` unchanged and `in_ready`=0. On release, `in_ready`=1 next cycle and a back-to-back pair is accepted.
- Pull `rst_n` low at MULT count 10 → `out_valid`=0 and `in_ready`=0 immediately. `in_ready`=1 one edge after release, and the next operation is correct.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand classes, special constants and FSM states.
// Reused by the sequential multiplier and the divider.
package fp_pkg;

    typedef enum logic [2:0] {
        CLS_ZERO    = 3'd0,
        CLS_NORMAL  = 3'd1,
        CLS_INF_POS = 3'd2,
        CLS_INF_NEG = 3'd3,
        CLS_NAN     = 3'd4
    } fp_class_e;

    localparam logic [31:0] NAN_NUM = 32'hFF80_0001;
    localparam logic [30:0] INF_ABS = 31'h7F80_0000;
    localparam int          BIAS    = 127;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MULT,
        ST_NORM,
        ST_DONE
    } fp_state_e;

    // Result of a multiplication where at least one operand is not NORMAL.
    function automatic logic [31:0] mul_special(input fp_class_e ca, input fp_class_e cb,
                                                input logic s);
        logic a_inf;
        logic b_inf;
        a_inf = (ca == CLS_INF_POS) || (ca == CLS_INF_NEG);
        b_inf = (cb == CLS_INF_POS) || (cb == CLS_INF_NEG);
        if (ca == CLS_NAN || cb == CLS_NAN)
            return NAN_NUM;
        if ((ca == CLS_ZERO && b_inf) || (a_inf && cb == CLS_ZERO))
            return NAN_NUM;
        if (a_inf || b_inf)
            return {s, INF_ABS};
        return 32'h0000_0000;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Classifies one IEEE-754 single-precision operand; subnormals are treated as zero.
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0] x,
    output fp_class_e   cls,
    output logic        is_special
);

    always_comb begin
        if (x[30:23] == 8'h00)
            cls = CLS_ZERO;
        else if (x[30:23] == 8'hFF)
            cls = (x[22:0] != 23'h0) ? CLS_NAN : (x[31] ? CLS_INF_NEG : CLS_INF_POS);
        else
            cls = CLS_NORMAL;
        is_special = (cls != CLS_NORMAL);
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential single-precision multiplier: special-value table plus a shift-add mantissa
// product (one multiplier bit per cycle). Define FP_MUL_RNE_EN for round-to-nearest-even,
// otherwise the mantissa is truncated.
module fp_mul_seq
    import fp_pkg::*;
#(
    parameter int MANT_W = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic        special
);

    localparam int PW    = 2 * MANT_W;
    localparam int FW    = MANT_W - 1;
    localparam int CNT_W = $clog2(MANT_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MANT_W - 1);

    fp_class_e cls_a, cls_b;
    logic      sp_a, sp_b;

    fp_classify u_cls_a (.x(a), .cls(cls_a), .is_special(sp_a));
    fp_classify u_cls_b (.x(b), .cls(cls_b), .is_special(sp_b));

    fp_state_e          state, state_d;
    logic [PW-1:0]      acc, acc_d;
    logic [PW-1:0]      mcand, mcand_d;
    logic [MANT_W-1:0]  mplier, mplier_d;
    logic [CNT_W-1:0]   count, count_d;
    logic signed [9:0]  exp_r, exp_d;
    logic               sign_r, sign_d;
    logic [31:0]        out_d;
    logic               special_d;
    logic [31:0]        norm_result;

    // Normalise, round and pack the finished product.
    logic               top;
    logic [FW-1:0]      frac;
    logic               round_up;
    logic [MANT_W:0]    rnd_sum;
    logic [FW-1:0]      frac_f;
    logic signed [9:0]  exp_f;

    always_comb begin
        top  = acc[PW-1];
        frac = top ? acc[PW-2 -: FW] : acc[PW-3 -: FW];
`ifdef FP_MUL_RNE_EN
        begin
            logic guard;
            logic sticky;
            guard    = top ? acc[PW-1-MANT_W] : acc[PW-2-MANT_W];
            sticky   = top ? (|acc[PW-2-MANT_W:0]) : (|acc[PW-3-MANT_W:0]);
            round_up = guard & (sticky | frac[0]);
        end
`else
        round_up = 1'b0;
`endif
        rnd_sum = {2'b01, frac} + {{MANT_W{1'b0}}, round_up};
        frac_f  = rnd_sum[MANT_W] ? rnd_sum[MANT_W-1:1] : rnd_sum[FW-1:0];
        exp_f   = exp_r + {9'd0, top} + {9'd0, rnd_sum[MANT_W]};
        if (exp_f >= 10'sd255)
            norm_result = {sign_r, INF_ABS};
        else if (exp_f <= 10'sd0)
            norm_result = 32'h0000_0000;
        else
            norm_result = {sign_r, exp_f[7:0], frac_f};
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state;
        acc_d     = acc;
        mcand_d   = mcand;
        mplier_d  = mplier;
        count_d   = count;
        exp_d     = exp_r;
        sign_d    = sign_r;
        out_d     = out;
        special_d = special;
        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    sign_d = a[31] ^ b[31];
                    if (sp_a || sp_b) begin
                        out_d     = mul_special(cls_a, cls_b, a[31] ^ b[31]);
                        special_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        acc_d    = '0;
                        mcand_d  = PW'({1'b1, a[FW-1:0]});
                        mplier_d = {1'b1, b[FW-1:0]};
                        count_d  = '0;
                        exp_d    = 10'({2'b00, a[30:23]}) + 10'({2'b00, b[30:23]}) - 10'(BIAS);
                        state_d  = ST_MULT;
                    end
                end
            end
            ST_MULT: begin
                if (mplier[0])
                    acc_d = acc + mcand;
                mcand_d  = mcand << 1;
                mplier_d = mplier >> 1;
                count_d  = count + 1'b1;
                if (count == LAST)
                    state_d = ST_NORM;
            end
            ST_NORM: begin
                out_d     = norm_result;
                special_d = 1'b0;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            special   <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            count     <= '0;
            exp_r     <= '0;
            sign_r    <= 1'b0;
        end else begin
            state     <= state_d;
            in_ready  <= (state_d == ST_IDLE);
            out_valid <= (state_d == ST_DONE);
            out       <= out_d;
            special   <= special_d;
            acc       <= acc_d;
            mcand     <= mcand_d;
            mplier    <= mplier_d;
            count     <= count_d;
            exp_r     <= exp_d;
            sign_r    <= sign_d;
        end
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq: special table, normal products, rounding, backpressure
// and mid-operation reset, with hand-computed expected results.
module tb_fp_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out;
    logic        special;

    int total = 0;
    int bad   = 0;

`ifdef FP_MUL_RNE_EN
    localparam logic [31:0] TIE_EXP = 32'h3FC0_0002;
`else
    localparam logic [31:0] TIE_EXP = 32'h3FC0_0001;
`endif

    always #5 clk = ~clk;

    fp_mul_seq #(.MANT_W(24)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .special   (special)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] xa, input logic [31:0] xb);
        int n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        a        = xa;
        b        = xb;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        check("out_valid_wait", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_rdy_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                       input logic [31:0] exp_out, input logic exp_sp, input int exp_lat);
        int lat;
        send(xa, xb);
        wait_result(lat);
        check({tag, "_out"}, out, exp_out);
        check({tag, "_special"}, {31'd0, special}, {31'd0, exp_sp});
        check({tag, "_lat"}, lat, exp_lat);
        release_result(tag);
    endtask

    initial begin
        int lat;

        // Reset values while rst_n is held low.
        #3;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out", out, 32'd0);
        check("rst_special", {31'd0, special}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        check("rel_in_ready_lo", {31'd0, in_ready}, 32'd0);
        step();
        check("rel_in_ready_hi", {31'd0, in_ready}, 32'd1);

        run("mul3x2",  32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 1'b0, 26);
        run("zero_inf", 32'h0000_0000, 32'h7F80_0000, 32'hFF80_0001, 1'b1, 1);
        run("zero_nan", 32'h0000_0000, 32'h7FC0_0000, 32'hFF80_0001, 1'b1, 1);
        run("neg_inf", 32'hC000_0000, 32'h7F80_0000, 32'hFF80_0000, 1'b1, 1);
        run("ovf",     32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 1'b0, 26);
        run("tie",     32'h3FC0_0000, 32'h3F80_0001, TIE_EXP,       1'b0, 26);
        run("neg3x2",  32'hC040_0000, 32'h4000_0000, 32'hC0C0_0000, 1'b0, 26);
        run("sq1p5",   32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0, 26);
        run("one",     32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 26);
        run("unf",     32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 26);
        run("subn",    32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 1'b1, 1);

        // Backpressure: result must hold while out_ready stays low.
        send(32'h4040_0000, 32'h4000_0000);
        wait_result(lat);
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_out", out, 32'h40C0_0000);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        a        = 32'h3F80_0000;
        b        = 32'h4000_0000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("b2b_accepted", {31'd0, in_ready}, 32'd0);
        wait_result(lat);
        check("b2b_out", out, 32'h4000_0000);
        check("b2b_lat", lat, 26);
        release_result("b2b");

        // Reset in the middle of MULT (count 10).
        send(32'h4040_0000, 32'h4000_0000);
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("mid_rst_out", out, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        check("mid_rel_lo", {31'd0, in_ready}, 32'd0);
        step();
        check("mid_rel_hi", {31'd0, in_ready}, 32'd1);
        run("after_rst", 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0, 26);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
